// File: rtl/gnn_load_pkg.sv
// Shared definitions for the load scheduler: instruction field positions,
// buffer-group encodings, FSM states and the instruction validity check.
package gnn_load_pkg;

  localparam int GRP_LSB       = 0;
  localparam int GRP_MSB       = 5;
  localparam int BUF_START_LSB = 32;
  localparam int BUF_START_MSB = 47;
  localparam int BUF_LEN_LSB   = 48;
  localparam int BUF_LEN_MSB   = 63;
  localparam int DRAM_START_LSB = 64;
  localparam int DRAM_START_MSB = 95;
  localparam int DRAM_LEN_LSB  = 96;
  localparam int DRAM_LEN_MSB  = 127;

  localparam logic [5:0] GRP_BUF0  = 6'b000001;
  localparam logic [5:0] GRP_BUF1A = 6'b000010;
  localparam logic [5:0] GRP_BUF1B = 6'b000100;
  localparam logic [5:0] GRP_BUF2A = 6'b001000;
  localparam logic [5:0] GRP_BUF2B = 6'b010000;

  localparam logic [5:0] GRP_ALL =
    GRP_BUF0 | GRP_BUF1A | GRP_BUF1B | GRP_BUF2A | GRP_BUF2B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_RETIRE
  } sched_st_e;

  // A group must name exactly one real buffer and the length must be
  // non-zero; anything else would hang the load unit.
  function automatic logic inst_ok(
    input logic [5:0]  grp,
    input logic [15:0] len
  );
    return ((grp & ~GRP_ALL) == 6'd0) && $onehot(grp) && (len != 16'd0);
  endfunction

endpackage

// File: rtl/load_sched_fifo.sv
// Synchronous FIFO holding {offset, instruction} entries for the scheduler.
// Head is read combinationally; pushes on full and pops on empty are dropped.
module load_sched_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 192
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_din,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rp];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset; only occupied slots are ever read.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wp] <= i_din;
  end

endmodule

// File: rtl/load_sched.sv
// Load-instruction scheduler: queues decoder loads, issues one at a time to
// the load unit once its buffer group is free. Optional LOAD_SCHED_PERF_EN.
module load_sched
  import gnn_load_pkg::*;
#(
  parameter int LOAD_INST_BIT_WIDTH = 128,
  parameter int C_M_AXI_ADDR_WIDTH  = 64,
  parameter int QUEUE_DEPTH         = 8
) (
  input  logic                           kernel_clk,
  input  logic                           kernel_rst,
  input  logic                           inst_valid,
  output logic                           inst_ready,
  input  logic [LOAD_INST_BIT_WIDTH-1:0] inst_data,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]  inst_addr_offset,
  input  logic [5:0]                     buf_busy_mask,
  output logic                           load_ap_start,
  input  logic                           load_ap_done,
  output logic [LOAD_INST_BIT_WIDTH-1:0] load_ctrl_instruction,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]  load_ctrl_addr_offset,
  output logic                           done_valid,
  output logic                           done_err,
  output logic [5:0]                     done_group,
`ifdef LOAD_SCHED_PERF_EN
  output logic [31:0]                    perf_busy_cycles,
  output logic [31:0]                    perf_inst_count,
`endif
  output logic                           sched_idle
);

  localparam int IW = LOAD_INST_BIT_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int FW = AW + IW;
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  sched_st_e r_state;
  sched_st_e w_next;

  logic [IW-1:0] r_ctrl_inst;
  logic [AW-1:0] r_ctrl_off;
  logic          r_idle;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [FW-1:0] w_head;
  logic [IW-1:0] w_head_inst;
  logic [AW-1:0] w_head_off;
  logic [5:0]    w_head_grp;
  logic [15:0]   w_head_len;
  logic          w_head_ok;
  logic          w_issue;

  logic          w_start;
  logic          w_done_v;
  logic          w_done_err;
  logic [5:0]    w_done_grp;

  assign w_push = inst_valid && !w_full;
  assign w_pop  = (r_state == ST_RETIRE);

  load_sched_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .W     (FW)
  ) u_fifo (
    .i_clk   (kernel_clk),
    .i_rst   (kernel_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   ({inst_addr_offset, inst_data}),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_cnt)
  );

  assign w_head_inst = w_head[IW-1:0];
  assign w_head_off  = w_head[FW-1:IW];
  assign w_head_grp  = w_head_inst[GRP_MSB:GRP_LSB];
  assign w_head_len  = w_head_inst[BUF_LEN_MSB:BUF_LEN_LSB];
  assign w_head_ok   = inst_ok(w_head_grp, w_head_len);

  assign w_cnt_nxt = w_cnt + CW'(w_push) - CW'(w_pop);
  assign w_issue   = (r_state == ST_IDLE) && (w_next == ST_START);

  // FSM state register.
  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  // Next state: a blocked head stalls the whole queue; done only counts in WAIT.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          if (!w_head_ok)
            w_next = ST_RETIRE;
          else if ((w_head_grp & buf_busy_mask) == 6'd0)
            w_next = ST_START;
        end
      end
      ST_START:  w_next = ST_WAIT;
      ST_WAIT:   if (load_ap_done) w_next = ST_RETIRE;
      ST_RETIRE: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; retire info comes from the still-queued head.
  always_comb begin
    w_start    = 1'b0;
    w_done_v   = 1'b0;
    w_done_err = 1'b0;
    w_done_grp = 6'd0;
    unique case (1'b1)
      (r_state == ST_START):  w_start = 1'b1;
      (r_state == ST_RETIRE): begin
        w_done_v   = 1'b1;
        w_done_err = !w_head_ok;
        w_done_grp = w_head_grp;
      end
      default: ;
    endcase
  end

  // Command registers to load, frozen from issue until the next issue.
  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      r_ctrl_inst <= '0;
      r_ctrl_off  <= '0;
    end else if (w_issue) begin
      r_ctrl_inst <= w_head_inst;
      r_ctrl_off  <= w_head_off;
    end
  end

  // Idle flag looks ahead so it rises right after the last retire.
  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) r_idle <= 1'b1;
    else            r_idle <= (w_next == ST_IDLE) && (w_cnt_nxt == '0);
  end

`ifdef LOAD_SCHED_PERF_EN
  logic [31:0] r_perf_busy;
  logic [31:0] r_perf_cnt;

  // Saturating counters of load-busy cycles and successful retires.
  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      r_perf_busy <= '0;
      r_perf_cnt  <= '0;
    end else begin
      if (((r_state == ST_START) || (r_state == ST_WAIT)) &&
          (r_perf_busy != '1))
        r_perf_busy <= r_perf_busy + 1'b1;
      if ((r_state == ST_RETIRE) && w_head_ok && (r_perf_cnt != '1))
        r_perf_cnt <= r_perf_cnt + 1'b1;
    end
  end

  assign perf_busy_cycles = r_perf_busy;
  assign perf_inst_count  = r_perf_cnt;
`endif

  assign inst_ready            = !w_full;
  assign load_ap_start         = w_start;
  assign load_ctrl_instruction = r_ctrl_inst;
  assign load_ctrl_addr_offset = r_ctrl_off;
  assign done_valid            = w_done_v;
  assign done_err              = w_done_err;
  assign done_group            = w_done_grp;
  assign sched_idle            = r_idle;

endmodule

// File: doc/load_sched.md
# load_sched

Load-instruction scheduler in front of the `load` unit. It queues load instructions from the instruction decoder and holds back each instruction until its target buffer group is free. It issues each instruction to `load` with a single-cycle `ap_start` pulse, waits for `ap_done`, and reports retirement. Malformed instructions are retired with an error and never reach `load`, because they would hang it.

## Interface
- LOAD_INST_BIT_WIDTH, 128, instruction width; fields: group [5:0], buffer length [63:48].
- C_M_AXI_ADDR_WIDTH, 64, DRAM base-offset width.
- QUEUE_DEPTH, 8, instruction queue entries; power of 2, ≥2.
- kernel_clk  in  1  clock.
- kernel_rst  in  1  reset; asynchronous, active-high.
- inst_valid  in  1  push request.
- inst_ready  out  1  queue not full.
- inst_data  in  LOAD_INST_BIT_WIDTH  load instruction.
- inst_addr_offset  in  C_M_AXI_ADDR_WIDTH  DRAM base offset for this instruction.
- buf_busy_mask  in  6  one bit per buffer group, same one-hot encoding as the group field; 1 = consumer owns the group.
- load_ap_start  out  1  start pulse to `load`.
- load_ap_done  in  1  completion pulse from `load`.
- load_ctrl_instruction  out  LOAD_INST_BIT_WIDTH  head instruction.
- load_ctrl_addr_offset  out  C_M_AXI_ADDR_WIDTH  head offset.
- done_valid  out  1  one-cycle retire pulse.
- done_err  out  1  retired instruction was rejected; valid with done_valid.
- done_group  out  6  group of the retired instruction.
- sched_idle  out  1  queue empty and FSM in IDLE.
- perf_busy_cycles  out  32  present only with `LOAD_SCHED_PERF_EN`.
- perf_inst_count  out  32  present only with `LOAD_SCHED_PERF_EN`.

## Operation
- Queue: synchronous FIFO.
  - Push when `inst_valid && inst_ready`.
  - `inst_ready = !full`. A push is refused on a full queue even if a pop happens in the same cycle.
  - The queue pops only in RETIRE.
- FSM states: IDLE, START, WAIT, RETIRE.
- IDLE, queue empty: stay in IDLE.
- IDLE, head invalid: go to RETIRE with `done_err=1`, without starting `load`.
  - Invalid means the group field is not one-hot within bits [4:0], or the length field [63:48] is 0.
- IDLE, head valid:
  - If `(group & buf_busy_mask)==0`, go to START.
  - Otherwise stay in IDLE (blocked). Re-evaluate the mask every cycle.
- START: `load_ap_start=1` for exactly one cycle, then go to WAIT.
- WAIT: on `load_ap_done`, go to RETIRE. There is no timeout.
- RETIRE:
  - Assert `done_valid`, with `done_err` and `done_group` set from the head entry.
  - Pop the head, then go to IDLE.
- `load_ap_done` is ignored outside WAIT. This masks the power-up done pulse `load` emits after reset.
- `load_ctrl_instruction` and `load_ctrl_addr_offset` are registered copies of the head entry.
  - They are updated when IDLE moves to START and held unchanged through WAIT and RETIRE.
- Only one instruction is ever outstanding at `load`. There is no reordering; a blocked head blocks the whole queue.

## Timing
- Reset values:
  - Outputs: `inst_ready=1`, `load_ap_start=0`, `done_valid=0`, `done_err=0`, `done_group=0`, `sched_idle=1`.
  - Control outputs to `load`: 0. Perf counters: 0.
  - State: queue empty, FSM in IDLE.
- Push at edge t into an empty queue in IDLE: the head is visible at t+1, `load_ap_start` is high during cycle t+2 if not blocked.
- `load_ap_done` sampled at edge d: `done_valid` high during cycle d+1. The next instruction's `load_ap_start` can be high during cycle d+3 at the earliest.
- Rejected instruction: head visible at t+1, `done_valid` during t+2.
- `sched_idle` is registered: it goes high one cycle after the last RETIRE.
- Reset mid-WAIT clears the queue and the FSM. The integrator resets `load` on the same `kernel_rst`.
- Occupancy counter is $clog2(QUEUE_DEPTH)+1 bits wide. Pointers wrap modulo QUEUE_DEPTH.

## Configuration
- `LOAD_SCHED_PERF_EN` defined:
  - `perf_busy_cycles` increments every cycle the FSM is in START or WAIT.
  - `perf_inst_count` increments on every non-error retire.
  - Both counters saturate at 2^32-1 and clear only on reset.
- Not defined: both perf ports and their registers are absent.

## Structure
- Package `gnn_load_pkg`:
  - Instruction field position constants: group, buffer start, buffer length, DRAM start, DRAM byte length.
  - Group one-hot constants for buffers 0, 1A, 1B, 2A, 2B.
  - FSM state enum.
  - Validity-check function.
- Sub-module `load_sched_fifo`: parameterised sync FIFO carrying {offset, instruction}, with full/empty flags and a count.

## Test plan
- Single instruction, group=6'b000001, length=4: `ap_start` one cycle at t+2; bench `ap_done` 10 cycles later -> `done_valid` next cycle, `done_group`=1, `done_err`=0.
- Busy block: group=6'b001000 with `buf_busy_mask`=6'b001000 for 20 cycles -> no `ap_start` until 1 cycle after the mask clears.
- Reject: length=0, and separately group=6'b000011 -> `done_err`=1 and no `ap_start`; the following valid instruction issues normally.
- Back-pressure: push 9 instructions at QUEUE_DEPTH=8 with `load` stalled -> `inst_ready`=0 after 8 pushes; 9th accepted after the first retire; order preserved.
- Spurious done: `ap_done` pulsed in IDLE and START -> ignored. Reset asserted mid-WAIT -> all outputs at reset values, queue empty.
- With `LOAD_SCHED_PERF_EN`: 3 valid instructions plus 1 reject -> `perf_inst_count`=3, `perf_busy_cycles` = sum of START+WAIT cycles.
